// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the data-memory pipeline stage: state encoding,
// default geometry/latency and the word-address width helper.
package data_mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

  function automatic int word_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_WORD_AW = word_aw(DEF_DEPTH);

endpackage

// File: rtl/data_mem_array.sv
// Word-wide data storage: one synchronous write port, one registered read
// port, contents and read register cleared by the asynchronous reset.
module data_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_stage.sv
// Load/store stage between EXEC and WB: accepts one request at a time,
// waits LATENCY cycles, then holds a registered response until WB takes it.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = word_aw(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              err;
  logic              mem_we;
  logic              mem_re;
  logic [AW-1:0]     index;
  logic [31:0]       rd_data;

  assign accept = req_valid && req_ready_q;
  assign index  = addr_q[AW+1:2];
  assign err    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  // The registered read is launched one edge ahead of WAIT->RESP (the
  // "last" cycle), so the data is ready to land in rsp_rdata on that edge.
  assign mem_re = (state_q == ST_WAIT) && !last_q && (cnt_q == '0);
  assign mem_we = (state_q == ST_WAIT) && last_q && we_q && !err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
          last_d  = 1'b0;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_WAIT: begin
        if (last_q) begin
          state_d     = ST_RESP;
          last_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err;
          rsp_rdata_d = (!we_q && !err) ? rd_data : 32'h0;
        end else if (cnt_q == '0) begin
          last_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (index),
    .wdata (wdata_q),
    .re    (mem_re),
    .raddr (index),
    .rdata (rd_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage (DEPTH=256, LATENCY=2): handshake timing,
// error handling, back-pressure, reset abort and back-to-back throughput.
module tb_data_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  data_mem_stage #(
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns the cycle number of the accepting edge.
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      output int acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'b0, req_ready}, 32'h1);
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int acc;
    send(we, a, d, acc);
    wait_rsp();
    chk({tag, "_lat"}, 32'(cyc - acc), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    $display("txn %s we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, a, d, rsp_rdata, rsp_err, cyc - acc);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, {31'b0, rsp_valid}, 32'h0);
  endtask

  initial begin
    int acc;
    int acc_prev;
    int n;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready_pre", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("rel_req_ready_post", {31'b0, req_ready}, 32'h1);

    // Basic store/load round trip
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Misaligned / out-of-range; 0x400 would alias word 0 if unchecked
    txn("ld13", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    txn("st400", 1'b1, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1);
    txn("ld00", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Back-pressure: hold rsp_ready low 5 cycles with a new request waiting
    send(1'b0, 32'h10, 32'h0, acc);
    wait_rsp();
    chk("bp_lat", 32'(cyc - acc), 32'd3);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h24;
    req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
      @(negedge clk);
    end
    $display("txn bp_hold ld addr=00000010 rdata=%h held=5", rsp_rdata);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
    chk("bp_release_busy", {31'b0, busy}, 32'h0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'h1);
    acc = cyc + 1;
    @(negedge clk);
    chk("bp_held_taken", {31'b0, busy}, 32'h1);
    // Inputs wiggled outside IDLE must not disturb the latched store
    req_valid = 1'b0;
    req_addr  = 32'h28;
    req_wdata = 32'hBAD0BAD0;
    wait_rsp();
    chk("bp_st_lat", 32'(cyc - acc), 32'd3);
    chk("bp_st_err", {31'b0, rsp_err}, 32'h0);
    $display("txn bp_store we=1 addr=00000024 wdata=11111111 lat=%0d", cyc - acc);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    txn("ld24", 1'b0, 32'h24, 32'h0, 32'h11111111, 1'b0);
    txn("ld28", 1'b0, 32'h28, 32'h0, 32'h0, 1'b0);

    // Reset in WAIT aborts a store and clears memory
    send(1'b1, 32'h20, 32'h12345678, acc);
    chk("wr_busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wr_rst_busy", {31'b0, busy}, 32'h0);
    chk("wr_rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("wr_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("wr_rst_rdata", rsp_rdata, 32'h0);
    $display("txn rst_in_wait st addr=00000020 busy=%0d", busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_rel_ready", {31'b0, req_ready}, 32'h1);
    txn("ld20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    txn("ld10_clr", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // Back-to-back stores with rsp_ready tied high
    rsp_ready = 1'b1;
    acc_prev  = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'(i * 4);
      req_wdata = 32'hA5000000 + 32'(i);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_accept", {31'b0, req_ready}, 32'h1);
      acc = cyc + 1;
      if (i > 0) chk("b2b_period", 32'(acc - acc_prev), 32'd5);
      $display("txn b2b_st%0d we=1 addr=%h wdata=%h accept_cycle=%0d", i, req_addr, req_wdata, acc);
      acc_prev = acc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_idle", {31'b0, busy}, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("b2b_ld%0d", i), 1'b0, 32'(i * 4), 32'h0, 32'hA5000000 + 32'(i), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit data-memory words.
REQ-002 Parameter LATENCY, default 2: wait cycles between request acceptance and response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  EXEC stage presents a load/store request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rt register value).
REQ-010 rsp_valid  output  1  response available to WB stage.
REQ-011 rsp_ready  input  1  WB stage accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; reset state SHALL be IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; one request outstanding at most.
REQ-017 Handshake: a request is accepted on a rising edge with req_valid & req_ready; IDLE->WAIT, and we/addr/wdata are latched.
REQ-018 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; at 0, WAIT->RESP.
REQ-019 Total latency SHALL be exactly LATENCY+1 cycles: rsp_valid rises LATENCY+1 edges after the accepting edge.
REQ-020 Word index = latched addr[31:2]; error when addr[1:0] != 0 or index >= DEPTH.
REQ-021 Store without error SHALL write the memory on the WAIT->RESP edge; erroneous stores SHALL leave memory unchanged.
REQ-022 Load without error SHALL register mem[index] into rsp_rdata on the WAIT->RESP edge; erroneous loads return 0.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESP until rsp_ready is sampled high; then RESP->IDLE and rsp_valid falls.
REQ-024 req_ready SHALL remain 0 during the RESP->IDLE edge; the next request is accepted no earlier than the following edge.
REQ-025 Back-to-back throughput SHALL be one request per LATENCY+3 cycles when rsp_ready is tied high.
REQ-026 A load to an address stored by the previous request SHALL return the new data.
REQ-027 req_* inputs outside IDLE SHALL be ignored and SHALL NOT alter latched values.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, req_ready 0.
REQ-029 req_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-030 Memory contents SHALL be cleared to 0 by reset.
REQ-031 Reset during WAIT SHALL abort the pending store: memory is not written.
REQ-032 Reset during RESP SHALL drop the response without requiring rsp_ready.

Structure
REQ-033 Shared package SHALL hold the state encoding (IDLE, WAIT, RESP), default DEPTH and LATENCY, and the word-address width derived from DEPTH.
REQ-034 The storage array SHALL be a separate sub-module data_mem_array: one synchronous write port, one registered read port, async clear.
REQ-035 FSM, latency counter, request latch and error check SHALL reside in data_mem_stage.

Verification
REQ-036 Reset, then store 0xDEADBEEF to addr 0x10 and load 0x10 -> load rsp_rdata = 0xDEADBEEF, rsp_err 0, rsp_valid exactly 3 edges after acceptance (LATENCY=2).
REQ-037 Load from addr 0x13 and store to 0x400 (DEPTH=256) -> rsp_err 1, rsp_rdata 0; subsequent load of 0x0 returns 0 (memory unchanged).
REQ-038 Hold rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_rdata stable all 5 cycles, req_ready 0; request held on req_valid is not accepted until after release.
REQ-039 Assert rst_n low during WAIT of a store 0x12345678 to 0x20 -> outputs zero immediately; post-reset load of 0x20 returns 0.
REQ-040 rsp_ready tied high, 4 consecutive stores to 0x0,0x4,0x8,0xC -> one accepted every 5 cycles; loads return the stored values in order.
